// File: rtl/activation_pipeline.sv
// activation_pipeline: multi-lane requantise / activation stage.
// Each lane: arithmetic right shift -> saturate to OUT_W -> optional ReLU.
// Two registered stages, valid/ready on both sides, saturation event counter.
// Optional build macro ACTIVATION_ROUND_NEAREST_EN selects round-half-up
// shifting in stage 1 instead of plain floor shifting.
//
// Handshake: a beat moves across an interface on a clock edge where valid
// and ready are both 1. out_valid stays high, with out_data stable, until
// out_ready is seen high. in_ready and out_valid come only from registered
// state and out_ready, never from in_valid.
module activation_pipeline #(
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 8,
    parameter int LANES   = 4,
    parameter int SHIFT_W = 5,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACC_W-1:0]   in_acc,
    input  logic [SHIFT_W-1:0]       in_shift,
    input  logic                     in_output_layer,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [CNT_W-1:0]         sat_count,
    input  logic                     sat_clear
);

    localparam int SAT_N_W = $clog2(LANES + 1);
    localparam int TOP_W   = ACC_W - OUT_W + 1;

    // Pipeline state
    logic                     s1_valid_q;
    logic                     s1_mode_q;
    logic [LANES*ACC_W-1:0]   s1_data_q;
    logic [LANES*ACC_W-1:0]   s1_data_d;
    logic                     s2_valid_q;
    logic [LANES*OUT_W-1:0]   out_data_q;
    logic [LANES*OUT_W-1:0]   out_data_d;
    logic [CNT_W-1:0]         sat_count_q;
    logic [CNT_W-1:0]         sat_count_d;

    // Flow control
    logic adv1;
    logic adv2;
    logic s2_load;

    // Stage-2 lane scratch
    logic [LANES-1:0]         lane_sat;
    logic [SAT_N_W-1:0]       n_sat;
    logic [TOP_W-1:0]         lane_top;
    logic [OUT_W-1:0]         lane_out;
    logic [CNT_W:0]           cnt_sum;

    // Stage 2 advances when it is empty or its beat is being taken;
    // stage 1 advances when it is empty or stage 2 advances.
    assign adv2     = !s2_valid_q || out_ready;
    assign adv1     = !s1_valid_q || adv2;
    assign s2_load  = adv2 && s1_valid_q;
    assign in_ready = adv1;

    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign sat_count = sat_count_q;

`ifdef ACTIVATION_ROUND_NEAREST_EN
    // One spare bit so adding the rounding bias cannot overflow.
    logic signed [ACC_W:0] lane_ext;
    logic signed [ACC_W:0] lane_bias;
    logic signed [ACC_W:0] lane_shifted;

    // Stage-1 datapath: round-half-up arithmetic shift per lane.
    always_comb begin
        s1_data_d    = '0;
        lane_ext     = '0;
        lane_bias    = '0;
        lane_shifted = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_ext = {in_acc[i*ACC_W + ACC_W - 1], in_acc[i*ACC_W +: ACC_W]};
            if (in_shift == '0) begin
                lane_bias = '0;
            end else begin
                lane_bias = (ACC_W+1)'(1) <<< (in_shift - SHIFT_W'(1));
            end
            lane_shifted = (lane_ext + lane_bias) >>> in_shift;
            // For shift >= 1 the result always fits back in ACC_W bits.
            s1_data_d[i*ACC_W +: ACC_W] = lane_shifted[ACC_W-1:0];
        end
    end
`else
    logic signed [ACC_W-1:0] lane_in;

    // Stage-1 datapath: floor arithmetic shift per lane.
    always_comb begin
        s1_data_d = '0;
        lane_in   = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_in = $signed(in_acc[i*ACC_W +: ACC_W]);
            s1_data_d[i*ACC_W +: ACC_W] = lane_in >>> in_shift;
        end
    end
`endif

    // Stage-2 datapath: clamp, ReLU for hidden layers, count clamped lanes.
    always_comb begin
        out_data_d = '0;
        lane_sat   = '0;
        n_sat      = '0;
        lane_top   = '0;
        lane_out   = '0;
        for (int i = 0; i < LANES; i++) begin
            // The value fits in OUT_W signed bits iff every bit from the
            // OUT_W sign position upward agrees.
            lane_top    = s1_data_q[i*ACC_W + OUT_W - 1 +: TOP_W];
            lane_sat[i] = !((&lane_top) || !(|lane_top));
            if (!lane_sat[i]) begin
                lane_out = s1_data_q[i*ACC_W +: OUT_W];
            end else if (s1_data_q[i*ACC_W + ACC_W - 1]) begin
                lane_out = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                lane_out = {1'b0, {(OUT_W-1){1'b1}}};
            end
            if (!s1_mode_q && lane_out[OUT_W-1]) begin
                lane_out = '0;
            end
            out_data_d[i*OUT_W +: OUT_W] = lane_out;
            n_sat = n_sat + SAT_N_W'(lane_sat[i]);
        end
    end

    // Saturation counter next state: clear wins, otherwise sticky add.
    always_comb begin
        cnt_sum     = {1'b0, sat_count_q} + (CNT_W+1)'(n_sat);
        sat_count_d = sat_count_q;
        if (sat_clear) begin
            sat_count_d = '0;
        end else if (s2_load) begin
            sat_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    // Pipeline and counter registers; reset drops every in-flight beat.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            out_data_q  <= '0;
            sat_count_q <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_data_q <= s1_data_d;
                    s1_mode_q <= in_output_layer;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= out_data_d;
                end
            end
            sat_count_q <= sat_count_d;
        end
    end

endmodule

// File: tb/tb_activation_pipeline.sv
// Self-checking bench for activation_pipeline (default and
// ACTIVATION_ROUND_NEAREST_EN builds). A second instance with a 4-bit
// saturation counter shares all inputs to exercise the sticky limit.
module tb_activation_pipeline;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int LANES   = 4;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;
    localparam longint OUT_MAX = (longint'(1) <<< (OUT_W-1)) - 1;
    localparam longint OUT_MIN = -(longint'(1) <<< (OUT_W-1));

    logic                   clk;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*ACC_W-1:0] in_acc;
    logic [SHIFT_W-1:0]     in_shift;
    logic                   in_output_layer;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [CNT_W-1:0]       sat_count;
    logic                   sat_clear;

    logic                   in_ready_b;
    logic                   out_valid_b;
    logic [LANES*OUT_W-1:0] out_data_b;
    logic [3:0]             sat_count_b;

    // Scoreboard and bookkeeping
    logic [LANES*OUT_W-1:0] exp_q[$];
    int                     vectors;
    int                     miscompares;
    int                     sat_m16;
    int                     sat_m4;
    logic                   lit_en;
    logic [LANES*OUT_W-1:0] lit_exp;
    logic                   held_valid;
    logic [LANES*OUT_W-1:0] held_data;

    activation_pipeline #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_acc(in_acc), .in_shift(in_shift), .in_output_layer(in_output_layer),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_count(sat_count), .sat_clear(sat_clear)
    );

    activation_pipeline #(
        .ACC_W(ACC_W), .OUT_W(OUT_W), .LANES(LANES), .SHIFT_W(SHIFT_W), .CNT_W(4)
    ) dut_small (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_acc(in_acc), .in_shift(in_shift), .in_output_layer(in_output_layer),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
        .sat_count(sat_count_b), .sat_clear(sat_clear)
    );

    // Clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model for one beat
    function automatic void model_beat(input logic [LANES*ACC_W-1:0] acc,
                                       input logic [SHIFT_W-1:0] sh,
                                       input logic mode,
                                       output logic [LANES*OUT_W-1:0] res,
                                       output int nsat);
        longint a;
        longint v;
        res  = '0;
        nsat = 0;
        for (int i = 0; i < LANES; i++) begin
            a = longint'($signed(acc[i*ACC_W +: ACC_W]));
`ifdef ACTIVATION_ROUND_NEAREST_EN
            if (sh == 0) v = a;
            else         v = (a + (longint'(1) <<< (int'(sh) - 1))) >>> sh;
`else
            v = a >>> sh;
`endif
            if (v > OUT_MAX) begin
                v = OUT_MAX;
                nsat++;
            end else if (v < OUT_MIN) begin
                v = OUT_MIN;
                nsat++;
            end
            if (!mode && v < 0) v = 0;
            res[i*OUT_W +: OUT_W] = v[OUT_W-1:0];
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_beat(input int a0, input int a1, input int a2, input int a3,
                            input int sh, input bit mode);
        in_valid                = 1'b1;
        in_acc[0*ACC_W +: ACC_W] = a0;
        in_acc[1*ACC_W +: ACC_W] = a1;
        in_acc[2*ACC_W +: ACC_W] = a2;
        in_acc[3*ACC_W +: ACC_W] = a3;
        in_shift                = SHIFT_W'(sh);
        in_output_layer         = mode;
    endtask

    // One clock cycle: observe handshakes just before the edge, then advance
    // to the next falling edge where the caller drives new inputs.
    task automatic tick();
        logic [LANES*OUT_W-1:0] e;
        int                     ns;
        #1;
        if (held_valid) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(out_data), 64'(held_data));
        end
        if (reset_n && in_valid && in_ready) begin
            model_beat(in_acc, in_shift, in_output_layer, e, ns);
            if (lit_en) begin
                exp_q.push_back(lit_exp);
                lit_en = 1'b0;
            end else begin
                exp_q.push_back(e);
            end
            sat_m16 = (sat_m16 + ns > 65535) ? 65535 : sat_m16 + ns;
            sat_m4  = (sat_m4 + ns > 15) ? 15 : sat_m4 + ns;
        end
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
            else                   check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
        if (sat_clear) begin
            sat_m16 = 0;
            sat_m4  = 0;
        end
        held_valid = reset_n && out_valid && !out_ready;
        held_data  = out_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic check_sat(input string tag);
        check({tag, "_sat16"}, 64'(sat_count), 64'(sat_m16));
        check({tag, "_sat4"}, 64'(sat_count_b), 64'(sat_m4));
    endtask

    // Main sequence
    initial begin
        int accepted;
        int cyc;
        vectors         = 0;
        miscompares     = 0;
        sat_m16         = 0;
        sat_m4          = 0;
        lit_en          = 1'b0;
        lit_exp         = '0;
        held_valid      = 1'b0;
        held_data       = '0;
        reset_n         = 1'b0;
        in_valid        = 1'b0;
        in_acc          = '0;
        in_shift        = '0;
        in_output_layer = 1'b0;
        out_ready       = 1'b0;
        sat_clear       = 1'b0;

        @(negedge clk);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_data", 64'(out_data), 64'(0));
        check_sat("rst");

        // Basic shift, linear mode, 2-cycle latency
        out_ready = 1'b1;
        set_beat(1000, -1000, 200, -5, 3, 1'b1);
        lit_en  = 1'b1;
        lit_exp = 32'hFF19_837D;
        tick();
        in_valid = 1'b0;
        check("lat_cycle1", 64'(out_valid), 64'(0));
        tick();
        check("lat_cycle2", 64'(out_valid), 64'(1));
        drain();
        check_sat("t1");

        // Saturation in linear then hidden mode
        set_beat(32'h7FFF, -32'sh8000, 127, -128, 4, 1'b1);
        lit_en = 1'b1;
`ifdef ACTIVATION_ROUND_NEAREST_EN
        lit_exp = 32'hF808_807F;
`else
        lit_exp = 32'hF807_807F;
`endif
        tick();
        drain();
        check("t2_lin_sat", 64'(sat_count), 64'(2));
        set_beat(32'h7FFF, -32'sh8000, 127, -128, 4, 1'b0);
        lit_en = 1'b1;
`ifdef ACTIVATION_ROUND_NEAREST_EN
        lit_exp = 32'h0008_007F;
`else
        lit_exp = 32'h0007_007F;
`endif
        tick();
        drain();
        check("t2_relu_sat", 64'(sat_count), 64'(4));

        // Backpressure: out_ready low for the first 4 cycles
        out_ready = 1'b0;
        accepted  = 0;
        cyc       = 0;
        while (accepted < 5 && cyc < 40) begin
            set_beat(accepted * 300, -accepted * 77, 5000 - accepted, accepted - 200,
                     accepted + 1, accepted[0]);
            if (cyc == 4) out_ready = 1'b1;
            if (cyc == 2 || cyc == 3) begin
                check("bp_in_ready_low", 64'(in_ready), 64'(0));
                check("bp_head_data", 64'(out_data), 64'(exp_q[0]));
            end
            if (in_ready) accepted++;
            tick();
            cyc++;
        end
        check("bp_accepted", 64'(accepted), 64'(5));
        drain();
        check_sat("t3");

        // Reset with two beats in flight
        out_ready = 1'b0;
        set_beat(100000, 2, 3, 4, 0, 1'b1);
        tick();
        set_beat(5, 6, 7, 8, 1, 1'b0);
        tick();
        in_valid = 1'b0;
        reset_n  = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        sat_m16 = 0;
        sat_m4  = 0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check_sat("mid_rst");
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();

        // Build count to 9, then clear in the same cycle as a 4-lane load
        set_beat(100000, -100000, 300, -300, 0, 1'b1);
        tick();
        set_beat(100000, -100000, 300, -300, 0, 1'b0);
        tick();
        set_beat(1000, 0, 0, 0, 0, 1'b1);
        tick();
        drain();
        check("t5_sat9", 64'(sat_count), 64'(9));
        check_sat("t5_pre");
        set_beat(100000, -100000, 300, -300, 0, 1'b1);
        tick();
        in_valid  = 1'b0;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        #1;
        check("t5_clear_wins", 64'(sat_count), 64'(0));
        drain();
        check_sat("t5_post");
        for (int k = 0; k < 5; k++) begin
            set_beat(-70000 - k, 70000 + k, 129, -129, 0, k[0]);
            tick();
        end
        drain();
        check("t5_sat20", 64'(sat_count), 64'(20));
        check("t5_sat_stick", 64'(sat_count_b), 64'(15));

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < LANES; i++) begin
                if ($urandom_range(0, 1) == 0) in_acc[i*ACC_W +: ACC_W] = $urandom();
                else in_acc[i*ACC_W +: ACC_W] = 32'($urandom_range(0, 1023)) - 32'd512;
            end
            in_shift        = SHIFT_W'($urandom_range(0, 31));
            in_output_layer = 1'($urandom_range(0, 1));
            tick();
        end
        drain();
        check_sat("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
